spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Shares the single-port sync RAM between the SPI slave command stream and a local parallel requester (host/DMA side).
- Sits between the SPI slave's rx_data/rx_valid/dout/tx_valid connections and the RAM's din/rx_valid/dout/tx_valid connections.
- Sequences local requests into the RAM's two-word command protocol, keeps SPI address/data pairs atomic, and routes read data back to the requester that owns the read.

Parameters:
ADDR_SIZE, 8, RAM address width; command word width is ADDR_SIZE+2
LOCK_TIMEOUT, 64, cycles an open SPI address/data pair may block local access before the lock is dropped

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
spi_rx_data  input  ADDR_SIZE+2  command word from SPI slave; bits [ADDR_SIZE+1:ADDR_SIZE] are the opcode
spi_rx_valid  input  1  one-cycle strobe; no backpressure
spi_dout  output  8  read data to SPI slave
spi_tx_valid  output  1  one-cycle strobe qualifying spi_dout
ram_din  output  ADDR_SIZE+2  command word to RAM
ram_rx_valid  output  1  RAM command strobe
ram_dout  input  8  RAM read data
ram_tx_valid  input  1  RAM read-data strobe, asserted the cycle after an opcode-11 word is accepted
loc_req  input  1  local request; held high until loc_ack
loc_we  input  1  1 = write, 0 = read; stable while loc_req is high
loc_addr  input  ADDR_SIZE  local address
loc_wdata  input  8  local write data
loc_ack  output  1  one-cycle completion pulse
loc_rdata  output  8  read data, valid when loc_ack is high for a read
ovf_err  output  1  sticky flag: SPI word dropped

Behaviour:
- RAM opcodes: 00 latch write address; 01 write data to the latched address; 10 latch read address; 11 read (data field ignored).
- Reset: all outputs 0, FIFO empty, lock clear, state IDLE. Reset is asynchronous. A reset during a local transaction produces no loc_ack; the requester re-issues.
- SPI input FIFO: 2 entries. A word is pushed on the edge where spi_rx_valid is sampled high. If the FIFO is full, the word is dropped and ovf_err is set; it clears only on reset.
- All RAM and requester outputs are registered. ram_rx_valid and loc_ack are high for exactly one cycle per event.
- States: IDLE, SPI_ISSUE, SPI_RDWAIT, LOC_ADDR, LOC_DATA, LOC_RDWAIT.
- IDLE, priority 1: if the FIFO is non-empty, pop the word and go to SPI_ISSUE. The word drives ram_din with ram_rx_valid=1 during SPI_ISSUE.
- IDLE, priority 2: otherwise, if loc_req=1 and lock=0, go to LOC_ADDR.
- SPI latency: spi_rx_valid sampled at edge N with the FIFO empty and state IDLE gives ram_rx_valid high in the cycle after edge N+1.
- SPI_ISSUE: opcode 00 or 10 sets lock and clears the timeout counter. Opcode 01 or 11 clears lock. Opcode 11 goes to SPI_RDWAIT; all others go to IDLE.
- SPI_RDWAIT: on ram_tx_valid, register spi_dout=ram_dout with spi_tx_valid=1 next cycle, then go to IDLE. FIFO pushes continue in this state.
- LOC_ADDR: issue {00 or 10, loc_addr} according to loc_we.
- LOC_DATA: issue {01, loc_wdata} for a write, or {11, 0} for a read.
  - Write: loc_ack in the next cycle, then IDLE. Total write latency from grant is 3 cycles.
  - Read: go to LOC_RDWAIT.
- LOC_RDWAIT: on ram_tx_valid, register loc_rdata=ram_dout with loc_ack=1, then IDLE.
- A local transaction is never split. SPI words arriving during it are buffered; at most 1 arrives given the SPI bit rate.
- Lock (SPI pair open) blocks only local grants; queued SPI words are still issued.
- Timeout counter increments each cycle while lock=1. On reaching LOCK_TIMEOUT-1 it clears lock, which covers SS_n deasserted mid-pair.
- Simultaneous: if a FIFO push and an IDLE pop happen in the same cycle, both occur and the count is unchanged. If the FIFO is non-empty and loc_req=1 in IDLE, SPI wins.
- Read data is routed only by the current state, so exactly one requester owns an outstanding read. A ram_tx_valid in any other state is ignored.

Test Plan:
- Local write loc_addr=0x12, wdata=0xA5, then local read of 0x12. Required: RAM sees words 0x012, 0x1A5, 0x212, 0x300; write loc_ack 3 cycles after grant; read loc_ack with loc_rdata=0xA5.
- SPI words 0x034 then 0x15C at spaced intervals. Required: each reaches ram_din 2 cycles after spi_rx_valid. SPI read (0x234, 0x300) returns spi_dout=0x5C with spi_tx_valid one cycle after ram_tx_valid.
- SPI 0x040 issued, loc_req write asserted, SPI 0x111 ten cycles later. Required: no local grant until after 0x111 is issued, then the local write proceeds; RAM[0x40]=0x11.
- SPI 0x240 with no follow-up and loc_req read held. Required: local read granted exactly LOCK_TIMEOUT cycles after lock set.
- Three SPI words during a local read with RAM tx held off. Required: third word dropped, ovf_err=1 and stays 1; first two issued in order.
- rst_n pulsed low in LOC_DATA. Required: all outputs 0 immediately, no loc_ack; after release, re-asserted loc_req completes normally.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one single-port sync RAM between the SPI slave
// command stream and a local parallel requester. SPI words pass through a
// 2-entry FIFO and keep address/data pairs atomic through a lock with a
// timeout. Local requests are expanded into the RAM's two-word protocol,
// and read data is returned to whichever side owns the outstanding read.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [7:0]           spi_dout,
  output logic                 spi_tx_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  input  logic                 loc_req,
  input  logic                 loc_we,
  input  logic [ADDR_SIZE-1:0] loc_addr,
  input  logic [7:0]           loc_wdata,
  output logic                 loc_ack,
  output logic [7:0]           loc_rdata,
  output logic                 ovf_err
);

  localparam int CW    = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SPI_ISSUE  = 3'd1;
  localparam logic [2:0] S_SPI_RDWAIT = 3'd2;
  localparam logic [2:0] S_LOC_ADDR   = 3'd3;
  localparam logic [2:0] S_LOC_DATA   = 3'd4;
  localparam logic [2:0] S_LOC_RDWAIT = 3'd5;

  // SPI input FIFO
  logic [CW-1:0] fifo_mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          fifo_full, fifo_empty, push, pop;
  logic          ovf_q;

  // Sequencer and registered outputs
  logic [2:0]       state_q, state_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    ram_din_q, ram_din_d;
  logic             ram_rx_valid_q, ram_rx_valid_d;
  logic [7:0]       spi_dout_q, spi_dout_d;
  logic             spi_tx_valid_q, spi_tx_valid_d;
  logic             loc_ack_q, loc_ack_d;
  logic [7:0]       loc_rdata_q, loc_rdata_d;
  logic [1:0]       issue_op;

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  // A word arriving while the FIFO is full is dropped and flagged.
  assign push       = spi_rx_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // Opcode of the SPI word currently on ram_din (valid in S_SPI_ISSUE).
  assign issue_op   = ram_din_q[CW-1 -: 2];

  // FIFO entry storage.
  // NOTE: FIFO storage is not reset; count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= spi_rx_data;
  end

  // FIFO occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      if (spi_rx_valid && fifo_full) ovf_q <= 1'b1;
    end
  end

  // Sequencer: picks the next RAM word, tracks the SPI pair lock and routes read data.
  always_comb begin
    state_d        = state_q;
    lock_d         = lock_q;
    cnt_d          = cnt_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    spi_dout_d     = spi_dout_q;
    spi_tx_valid_d = 1'b0;
    loc_ack_d      = 1'b0;
    loc_rdata_d    = loc_rdata_q;

    // An open SPI pair is abandoned after LOCK_TIMEOUT cycles (e.g. SS_n
    // dropped between the address and data words).
    if (lock_q) begin
      if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) lock_d = 1'b0;
      else                                   cnt_d  = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d        = S_SPI_ISSUE;
          ram_din_d      = fifo_mem_q[rd_ptr_q];
          ram_rx_valid_d = 1'b1;
        end else if (loc_req && !lock_q && !loc_ack_q) begin
          // loc_ack_q guards the cycle where the requester still holds
          // loc_req for the transaction that has just been acknowledged.
          state_d        = S_LOC_ADDR;
          ram_din_d      = {(loc_we ? OP_WADDR : OP_RADDR), loc_addr};
          ram_rx_valid_d = 1'b1;
        end
      end
      S_SPI_ISSUE: begin
        if (!issue_op[0]) begin
          lock_d = 1'b1;
          cnt_d  = '0;
        end else begin
          lock_d = 1'b0;
        end
        state_d = (issue_op == OP_READ) ? S_SPI_RDWAIT : S_IDLE;
      end
      S_SPI_RDWAIT: begin
        if (ram_tx_valid) begin
          spi_dout_d     = ram_dout;
          spi_tx_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
      end
      S_LOC_ADDR: begin
        state_d        = S_LOC_DATA;
        ram_din_d      = loc_we ? {OP_WDATA, ADDR_SIZE'(loc_wdata)}
                                : {OP_READ, {ADDR_SIZE{1'b0}}};
        ram_rx_valid_d = 1'b1;
      end
      S_LOC_DATA: begin
        if (loc_we) begin
          loc_ack_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_LOC_RDWAIT;
        end
      end
      S_LOC_RDWAIT: begin
        if (ram_tx_valid) begin
          loc_rdata_d = ram_dout;
          loc_ack_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      lock_q         <= 1'b0;
      cnt_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      spi_dout_q     <= 8'h00;
      spi_tx_valid_q <= 1'b0;
      loc_ack_q      <= 1'b0;
      loc_rdata_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      lock_q         <= lock_d;
      cnt_q          <= cnt_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      spi_dout_q     <= spi_dout_d;
      spi_tx_valid_q <= spi_tx_valid_d;
      loc_ack_q      <= loc_ack_d;
      loc_rdata_q    <= loc_rdata_d;
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign spi_dout     = spi_dout_q;
  assign spi_tx_valid = spi_tx_valid_q;
  assign loc_ack      = loc_ack_q;
  assign loc_rdata    = loc_rdata_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed scenarios plus randomized SPI/local traffic
// against an expected-memory model; a simple sync RAM model sits on the RAM port.
module tb_spi_ram_arbiter;

  localparam int AS = 8;
  localparam int LT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AS+1:0] spi_rx_data = '0;
  logic          spi_rx_valid = 1'b0;
  logic [7:0]    spi_dout;
  logic          spi_tx_valid;
  logic [AS+1:0] ram_din;
  logic          ram_rx_valid;
  logic [7:0]    ram_dout = 8'h00;
  logic          ram_tx_valid = 1'b0;
  logic          loc_req = 1'b0;
  logic          loc_we = 1'b0;
  logic [AS-1:0] loc_addr = '0;
  logic [7:0]    loc_wdata = 8'h00;
  logic          loc_ack;
  logic [7:0]    loc_rdata;
  logic          ovf_err;

  spi_ram_arbiter #(.ADDR_SIZE(AS), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_dout(spi_dout), .spi_tx_valid(spi_tx_valid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_ack(loc_ack), .loc_rdata(loc_rdata), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [29:0] all_outs = {spi_dout, spi_tx_valid, ram_din, ram_rx_valid, loc_ack, loc_rdata, ovf_err};

  // Sync RAM model: opcode 11 answers the next cycle unless held off.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ram_waddr = 8'h00, ram_raddr = 8'h00, pend_data = 8'h00;
  logic       ram_hold = 1'b0, pending = 1'b0;
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[AS+1:AS])
        2'b00: ram_waddr <= ram_din[7:0];
        2'b01: mem[ram_waddr] <= ram_din[7:0];
        2'b10: ram_raddr <= ram_din[7:0];
        default: begin
          if (ram_hold) begin pending <= 1'b1; pend_data <= mem[ram_raddr]; end
          else begin ram_tx_valid <= 1'b1; ram_dout <= mem[ram_raddr]; end
        end
      endcase
    end
    if (pending && !ram_hold) begin
      ram_tx_valid <= 1'b1;
      ram_dout     <= pend_data;
      pending      <= 1'b0;
    end
  end

  // Monitor: log every RAM command word with its cycle, sampled mid-cycle.
  logic [AS+1:0] ram_words [$];
  int            ram_cycs [$];
  int            last_rtx_cyc = -1;
  int            ack_count = 0;
  always @(negedge clk) begin
    if (ram_rx_valid) begin
      ram_words.push_back(ram_din);
      ram_cycs.push_back(cyc);
    end
    if (ram_tx_valid) last_rtx_cyc <= cyc;
    if (loc_ack) ack_count <= ack_count + 1;
  end

  // Expected memory contents, updated from the intent of each transaction.
  logic [7:0] exp_mem [256] = '{default: 8'h00};
  int rd_idx = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic skip_log();
    rd_idx = ram_words.size();
  endtask

  // Next logged RAM word must be w; c >= 0 also pins the cycle it appeared in.
  task automatic expect_ram(input string tag, input logic [AS+1:0] w, input int c);
    logic [AS+1:0] gw;
    int gc;
    gw = 'x;
    gc = -1;
    if (rd_idx < ram_words.size()) begin
      gw = ram_words[rd_idx];
      gc = ram_cycs[rd_idx];
      rd_idx++;
    end
    check({tag, " word"}, 32'(gw), 32'(w));
    if (c >= 0) check({tag, " cycle"}, gc, c);
  endtask

  task automatic spi_send(input logic [AS+1:0] w, output int c);
    @(negedge clk);
    spi_rx_data  = w;
    spi_rx_valid = 1'b1;
    c = cyc;
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  task automatic loc_txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int req_c, output int ack_c);
    @(negedge clk);
    loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    req_c = cyc; ack_c = -1; rd = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (loc_ack) begin ack_c = cyc; rd = loc_rdata; break; end
    end
    loc_req = 1'b0;
    check("loc_ack arrived", 32'(ack_c >= 0), 32'd1);
  endtask

  task automatic wait_spi_tx(output logic [7:0] d, output int c);
    c = -1; d = 'x;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (spi_tx_valid) begin d = spi_dout; c = cyc; break; end
    end
    check("spi_tx_valid arrived", 32'(c >= 0), 32'd1);
  endtask

  initial begin
    logic [7:0] rd, d;
    logic [7:0] a;
    int rq, ak, c1, c2, c3, c4, tc, snap, kind;

    // Reset state
    tick(3);
    check("reset outputs", 32'(all_outs), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Local write 0x12 <- 0xA5, then local read back
    skip_log();
    loc_txn(1'b1, 8'h12, 8'hA5, rd, rq, ak);
    exp_mem[8'h12] = 8'hA5;
    check("loc write ack latency", ak - rq, 3);
    loc_txn(1'b0, 8'h12, 8'h00, rd, rq, ak);
    check("loc read data", rd, exp_mem[8'h12]);
    check("loc read ack latency", ak - rq, 4);
    tick(2);
    expect_ram("loc seq 0", 10'h012, -1);
    expect_ram("loc seq 1", 10'h1A5, -1);
    expect_ram("loc seq 2", 10'h212, -1);
    expect_ram("loc seq 3", 10'h300, -1);

    // SPI write pair, then SPI read pair: each word reaches the RAM 2 cycles after its strobe
    skip_log();
    spi_send(10'h034, c1); tick(4);
    spi_send(10'h15C, c2); tick(4);
    exp_mem[8'h34] = 8'h5C;
    expect_ram("spi wr addr", 10'h034, c1 + 2);
    expect_ram("spi wr data", 10'h15C, c2 + 2);
    spi_send(10'h234, c3); tick(4);
    spi_send(10'h300, c4);
    wait_spi_tx(d, tc);
    check("spi read data", d, exp_mem[8'h34]);
    check("ram_tx_valid cycle", last_rtx_cyc, c4 + 3);
    check("spi_tx after ram_tx", tc, last_rtx_cyc + 1);
    expect_ram("spi rd addr", 10'h234, c3 + 2);

    // Open SPI pair blocks a pending local write until the data word is issued
    tick(2);
    skip_log();
    fork
      begin tick(1); loc_txn(1'b1, 8'h41, 8'h99, rd, rq, ak); end
      begin spi_send(10'h040, c1); tick(9); spi_send(10'h111, c2); end
    join
    exp_mem[8'h40] = 8'h11;
    exp_mem[8'h41] = 8'h99;
    tick(2);
    expect_ram("lock pair addr", 10'h040, -1);
    expect_ram("lock pair data", 10'h111, c2 + 2);
    expect_ram("lock local addr", 10'h041, c2 + 4);
    expect_ram("lock local data", 10'h199, -1);
    loc_txn(1'b0, 8'h40, 8'h00, rd, rq, ak);
    check("RAM[0x40] after pair", rd, exp_mem[8'h40]);
    check("RAM[0x40] model", mem[8'h40], exp_mem[8'h40]);

    // Dangling SPI address: local read granted LT cycles after the lock was set
    tick(2);
    skip_log();
    spi_send(10'h240, c1);
    loc_txn(1'b0, 8'h40, 8'h00, rd, rq, ak);
    check("timeout read data", rd, exp_mem[8'h40]);
    // Address word issued at c1+2, lock high from c1+3, grant LT cycles later, issue one after.
    expect_ram("timeout spi addr", 10'h240, c1 + 2);
    expect_ram("timeout local addr", 10'h240, c1 + 3 + LT + 1);

    // Three SPI words during a stalled local read: third is dropped
    tick(2);
    skip_log();
    ram_hold = 1'b1;
    fork
      loc_txn(1'b0, 8'h12, 8'h00, rd, rq, ak);
      begin
        tick(6);
        spi_send(10'h0A0, c1); tick(2);
        spi_send(10'h177, c2); tick(2);
        check("ovf before drop", ovf_err, 1'b0);
        spi_send(10'h2FF, c3); tick(1);
        check("ovf after drop", ovf_err, 1'b1);
        ram_hold = 1'b0;
      end
    join
    exp_mem[8'hA0] = 8'h77;
    check("stalled read data", rd, exp_mem[8'h12]);
    tick(12);
    expect_ram("stall 0", 10'h212, -1);
    expect_ram("stall 1", 10'h300, -1);
    expect_ram("stall 2", 10'h0A0, -1);
    expect_ram("stall 3", 10'h177, -1);
    check("dropped word not issued", ram_words.size(), rd_idx);
    check("RAM[0xA0] model", mem[8'hA0], exp_mem[8'hA0]);

    // Randomized traffic against the expected-memory model
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      a    = 8'(8'h60 + $urandom_range(0, 7));
      d    = 8'($urandom);
      case (kind)
        0: begin
          loc_txn(1'b1, a, d, rd, rq, ak);
          exp_mem[a] = d;
          check("rand loc write latency", ak - rq, 3);
        end
        1: begin
          loc_txn(1'b0, a, 8'h00, rd, rq, ak);
          check("rand loc read", rd, exp_mem[a]);
        end
        2: begin
          spi_send({2'b00, a}, c1); tick($urandom_range(2, 5));
          spi_send({2'b01, d}, c2); tick(4);
          exp_mem[a] = d;
        end
        default: begin
          spi_send({2'b10, a}, c1); tick($urandom_range(2, 5));
          spi_send(10'h300, c2);
          wait_spi_tx(rd, tc);
          check("rand spi read", rd, exp_mem[a]);
        end
      endcase
    end
    check("ovf stays set", ovf_err, 1'b1);

    // Reset during LOC_DATA: outputs clear at once and no ack is produced
    tick(2);
    @(negedge clk);
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h55; loc_wdata = 8'h3C;
    tick(2);
    check("in LOC_DATA", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h13C}));
    snap = ack_count;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(all_outs), 32'd0);
    tick(3);
    loc_req = 1'b0;
    rst_n = 1'b1;
    tick(3);
    check("no ack across reset", ack_count, snap);
    loc_txn(1'b1, 8'h55, 8'h3C, rd, rq, ak);
    exp_mem[8'h55] = 8'h3C;
    check("post-reset write latency", ak - rq, 3);
    loc_txn(1'b0, 8'h55, 8'h00, rd, rq, ak);
    check("post-reset read", rd, exp_mem[8'h55]);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
